// File: rtl/wb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter in front of the SDRAM slave.
// Holds the arbiter state encoding, the request bundle and the round-robin pick helper.
package wb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_SEL_W  = DEF_DATA_W / 8;
    localparam int WDOG_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  cyc;
        logic                  stb;
        logic                  we;
        logic [DEF_ADDR_W-1:0] adr;
        logic [DEF_DATA_W-1:0] dat_w;
        logic [DEF_SEL_W-1:0]  sel;
    } wb_req_t;

    // On a tie the master that did not win last time gets the bus.
    function automatic arb_state_t rr_pick(input logic req0, input logic req1,
                                           input logic rr_last);
        arb_state_t pick;
        pick = IDLE;
        if (req0 && req1) begin
            pick = rr_last ? OWN0 : OWN1;
        end else if (req0) begin
            pick = OWN0;
        end else if (req1) begin
            pick = OWN1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_sdram_arbiter_if.sv
// Bus bundle linking the two core ports, the arbiter and the SDRAM Wishbone slave port.
// slave: the arbiter's view of the bundle; master: the cores and the SDRAM side that face it.
interface wb_sdram_arbiter_if
    import wb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int SEL_W = DATA_W / 8;

    logic              io_m0_cyc;
    logic              io_m0_stb;
    logic              io_m0_we;
    logic [ADDR_W-1:0] io_m0_adr;
    logic [DATA_W-1:0] io_m0_dat_w;
    logic [SEL_W-1:0]  io_m0_sel;
    logic              io_m0_ack;
    logic              io_m0_err;
    logic [DATA_W-1:0] io_m0_dat_r;

    logic              io_m1_cyc;
    logic              io_m1_stb;
    logic              io_m1_we;
    logic [ADDR_W-1:0] io_m1_adr;
    logic [DATA_W-1:0] io_m1_dat_w;
    logic [SEL_W-1:0]  io_m1_sel;
    logic              io_m1_ack;
    logic              io_m1_err;
    logic [DATA_W-1:0] io_m1_dat_r;

    logic              io_s_cyc;
    logic              io_s_stb;
    logic              io_s_we;
    logic [ADDR_W-1:0] io_s_adr;
    logic [DATA_W-1:0] io_s_dat_w;
    logic [SEL_W-1:0]  io_s_sel;
    logic              io_s_ack;
    logic [DATA_W-1:0] io_s_dat_r;

    modport slave (
        input  io_m0_cyc, io_m0_stb, io_m0_we, io_m0_adr, io_m0_dat_w, io_m0_sel,
        output io_m0_ack, io_m0_err, io_m0_dat_r,
        input  io_m1_cyc, io_m1_stb, io_m1_we, io_m1_adr, io_m1_dat_w, io_m1_sel,
        output io_m1_ack, io_m1_err, io_m1_dat_r,
        output io_s_cyc, io_s_stb, io_s_we, io_s_adr, io_s_dat_w, io_s_sel,
        input  io_s_ack, io_s_dat_r
    );

    modport master (
        output io_m0_cyc, io_m0_stb, io_m0_we, io_m0_adr, io_m0_dat_w, io_m0_sel,
        input  io_m0_ack, io_m0_err, io_m0_dat_r,
        output io_m1_cyc, io_m1_stb, io_m1_we, io_m1_adr, io_m1_dat_w, io_m1_sel,
        input  io_m1_ack, io_m1_err, io_m1_dat_r,
        input  io_s_cyc, io_s_stb, io_s_we, io_s_adr, io_s_dat_w, io_s_sel,
        output io_s_ack, io_s_dat_r
    );

endinterface

// File: rtl/wb_ack_watchdog.sv
// Per-transfer ack watchdog: counts cycles an owner strobe waits and flags a one-cycle error
// once the wait reaches TIMEOUT, then restarts from zero.
module wb_ack_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic clock,
    input  logic reset,
    input  logic run_i,
    input  logic ack_i,
    output logic err_o
);

    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;

    assign err_o = run_i && (wdog_q == WDOG_W'(TIMEOUT));

    always_comb begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (!run_i || ack_i || err_o) begin
            wdog_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone classic arbiter (instruction fetch = master 0, load/store = master 1)
// in front of the SDRAM slave: round-robin grant, bus locked for the whole cycle, ack watchdog.
module wb_sdram_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clock,
    input  logic                     reset,
    wb_sdram_arbiter_if.slave        bus,
    output logic [1:0]               io_owner,
    output logic                     io_busy
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_t state_q;
    arb_state_t state_d;
    logic       rr_last_q;
    logic       rr_last_d;

    wb_req_t    m0_req;
    wb_req_t    m1_req;
    wb_req_t    own_req;
    logic       granted;
    logic       own_is_m1;
    logic       wd_run;
    logic       err_cycle;

    assign m0_req = '{cyc: bus.io_m0_cyc, stb: bus.io_m0_stb, we: bus.io_m0_we,
                      adr: bus.io_m0_adr, dat_w: bus.io_m0_dat_w, sel: bus.io_m0_sel};
    assign m1_req = '{cyc: bus.io_m1_cyc, stb: bus.io_m1_stb, we: bus.io_m1_we,
                      adr: bus.io_m1_adr, dat_w: bus.io_m1_dat_w, sel: bus.io_m1_sel};

    assign granted   = (state_q != IDLE);
    assign own_is_m1 = (state_q == OWN1);
    // Master 0 drives the address/data lines whenever nobody owns the bus.
    assign own_req   = own_is_m1 ? m1_req : m0_req;
    assign wd_run    = granted && own_req.cyc && own_req.stb;

    wb_ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .run_i (wd_run),
        .ack_i (bus.io_s_ack),
        .err_o (err_cycle)
    );

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        case (state_q)
            IDLE: begin
                state_d = rr_pick(m0_req.cyc, m1_req.cyc, rr_last_q);
                if (state_d != IDLE) begin
                    rr_last_d = (state_d == OWN1);
                end
            end
            OWN0: if (!m0_req.cyc) state_d = IDLE;
            OWN1: if (!m1_req.cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end

    // The grant comes straight from the state register, so an async reset drops the slave lines at once.
    always_comb begin
        bus.io_s_cyc   = 1'b0;
        bus.io_s_stb   = 1'b0;
        bus.io_s_we    = 1'b0;
        bus.io_s_adr   = ADDR_W'(own_req.adr);
        bus.io_s_dat_w = DATA_W'(own_req.dat_w);
        bus.io_s_sel   = SEL_W'(own_req.sel);
        bus.io_m0_ack  = 1'b0;
        bus.io_m0_err  = 1'b0;
        bus.io_m1_ack  = 1'b0;
        bus.io_m1_err  = 1'b0;
        if (granted) begin
            bus.io_s_cyc = own_req.cyc;
            bus.io_s_stb = own_req.stb && !err_cycle;
            bus.io_s_we  = own_req.we;
            if (own_is_m1) begin
                bus.io_m1_ack = bus.io_s_ack && m1_req.stb && !err_cycle;
                bus.io_m1_err = err_cycle;
            end else begin
                bus.io_m0_ack = bus.io_s_ack && m0_req.stb && !err_cycle;
                bus.io_m0_err = err_cycle;
            end
        end
    end

    assign bus.io_m0_dat_r = bus.io_s_dat_r;
    assign bus.io_m1_dat_r = bus.io_s_dat_r;

    assign io_owner = {state_q == OWN1, state_q == OWN0};
    assign io_busy  = granted;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter: stimulus pushes expected master responses into a
// scoreboard queue; a monitor pops and compares whenever any ack/err appears.
module tb_wb_sdram_arbiter;
    import wb_pkg::*;

    localparam int          TO      = 8;
    localparam logic [63:0] RD_DATA = 64'hDEADBEEF_CAFEF00D;
    localparam logic [3:0]  R_M0_ACK = 4'b0001;
    localparam logic [3:0]  R_M0_ERR = 4'b0010;
    localparam logic [3:0]  R_M1_ACK = 4'b0100;

    typedef struct packed {
        logic [3:0]  resp;
        logic        chk_data;
        logic [63:0] data;
    } sb_item_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] owner;
    logic       busy;
    int         checks   = 0;
    int         failures = 0;
    sb_item_t   exp_q[$];

    always #5 clock = ~clock;

    wb_sdram_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    wb_sdram_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (64),
        .TIMEOUT (TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .io_owner (owner),
        .io_busy  (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [1:0] own, input logic cyc,
                             input logic stb);
        check({tag, ".owner"}, 64'(owner), 64'(own));
        check({tag, ".busy"}, 64'(busy), 64'(|own));
        check({tag, ".s_cyc"}, 64'(bus.io_s_cyc), 64'(cyc));
        check({tag, ".s_stb"}, 64'(bus.io_s_stb), 64'(stb));
    endtask

    task automatic expect_resp(input logic [3:0] r, input logic cd, input logic [63:0] d);
        sb_item_t it;
        it.resp     = r;
        it.chk_data = cd;
        it.data     = d;
        exp_q.push_back(it);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    always @(negedge clock) begin : monitor
        logic [3:0] got;
        sb_item_t   it;
        got = {bus.io_m1_err, bus.io_m1_ack, bus.io_m0_err, bus.io_m0_ack};
        if (got != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'(got), 64'(0));
            end else begin
                it = exp_q.pop_front();
                check("resp_kind", 64'(got), 64'(it.resp));
                if (it.chk_data) begin
                    check("resp_dat_r", it.resp[2] ? bus.io_m1_dat_r : bus.io_m0_dat_r, it.data);
                end
            end
        end
    end

    initial begin : time_limit
        #200000;
        $display("FAIL tb_timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        bus.io_m0_cyc = 1'b0; bus.io_m0_stb = 1'b0; bus.io_m0_we = 1'b0;
        bus.io_m0_adr = '0;   bus.io_m0_dat_w = '0; bus.io_m0_sel = '0;
        bus.io_m1_cyc = 1'b0; bus.io_m1_stb = 1'b0; bus.io_m1_we = 1'b0;
        bus.io_m1_adr = '0;   bus.io_m1_dat_w = '0; bus.io_m1_sel = '0;
        bus.io_s_ack  = 1'b0; bus.io_s_dat_r = '0;

        // Reset held with master 0 requesting: everything stays quiet.
        bus.io_m0_cyc = 1'b1;
        bus.io_m0_stb = 1'b1;
        mid();
        check_bus("rst_hold", 2'b00, 1'b0, 1'b0);
        mid();

        // Simultaneous request out of reset, then alternation.
        next_cycle();
        reset = 1'b1;
        bus.io_m0_stb = 1'b0;
        bus.io_m1_cyc = 1'b1;
        mid(); check_bus("tie_req", 2'b00, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("tie_grant0", 2'b01, 1'b1, 1'b0);
        next_cycle(); bus.io_m0_cyc = 1'b0;
        mid(); check_bus("m0_release", 2'b01, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("dead_cycle", 2'b00, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("grant1", 2'b10, 1'b1, 1'b0);
        next_cycle(); bus.io_m1_cyc = 1'b0;
        mid(); check_bus("m1_release", 2'b10, 1'b0, 1'b0);
        next_cycle(); bus.io_m0_cyc = 1'b1; bus.io_m1_cyc = 1'b1;
        mid(); check_bus("tie2_req", 2'b00, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("tie2_grant0", 2'b01, 1'b1, 1'b0);
        next_cycle(); bus.io_m0_cyc = 1'b0; bus.io_m1_cyc = 1'b0;
        mid(); check_bus("tie2_release", 2'b01, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("tie2_idle", 2'b00, 1'b0, 1'b0);

        // Master 0 read at 0x100, slave acks 3 cycles after the strobe appears.
        next_cycle();
        bus.io_m0_cyc = 1'b1; bus.io_m0_stb = 1'b1; bus.io_m0_we = 1'b0;
        bus.io_m0_adr = 32'h100; bus.io_m0_sel = 8'hFF;
        mid(); check_bus("rd_req", 2'b00, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("rd_grant", 2'b01, 1'b1, 1'b1);
        check("rd_s_adr", 64'(bus.io_s_adr), 64'h100);
        check("rd_s_we", 64'(bus.io_s_we), 64'(0));
        next_cycle();
        next_cycle();
        next_cycle();
        bus.io_s_ack = 1'b1; bus.io_s_dat_r = RD_DATA;
        expect_resp(R_M0_ACK, 1'b1, RD_DATA);
        mid();
        next_cycle();
        bus.io_s_ack = 1'b0; bus.io_s_dat_r = '0;
        bus.io_m0_cyc = 1'b0; bus.io_m0_stb = 1'b0;
        mid(); check_bus("rd_release", 2'b01, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("rd_idle", 2'b00, 1'b0, 1'b0);

        // Master 1 locks the bus for 4 write beats while master 0 waits.
        next_cycle();
        bus.io_m0_cyc = 1'b1;
        bus.io_m1_cyc = 1'b1; bus.io_m1_stb = 1'b1; bus.io_m1_we = 1'b1;
        bus.io_m1_adr = 32'h200; bus.io_m1_sel = 8'hFF;
        mid(); check_bus("wr_req", 2'b00, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            bus.io_m1_adr   = 32'h200 + 32'(8 * b);
            bus.io_m1_dat_w = 64'h1111_2222_0000_0000 + 64'(b);
            bus.io_s_ack    = 1'b1;
            expect_resp(R_M1_ACK, 1'b0, '0);
            mid(); check_bus($sformatf("wr_beat%0d", b), 2'b10, 1'b1, 1'b1);
            check($sformatf("wr_beat%0d.adr", b), 64'(bus.io_s_adr), 64'h200 + 64'(8 * b));
            check($sformatf("wr_beat%0d.dat_w", b), bus.io_s_dat_w, 64'h1111_2222_0000_0000 + 64'(b));
        end
        check("wr_s_we", 64'(bus.io_s_we), 64'(1));
        check("wr_s_sel", 64'(bus.io_s_sel), 64'hFF);
        next_cycle();
        bus.io_m1_cyc = 1'b0; bus.io_m1_stb = 1'b0; bus.io_m1_we = 1'b0; bus.io_s_ack = 1'b0;
        mid(); check_bus("wr_release", 2'b10, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("wr_dead", 2'b00, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("m0_after_wait", 2'b01, 1'b1, 1'b0);

        // Watchdog: the slave never acks; an ack landing in the err cycle is dropped.
        next_cycle();
        bus.io_m0_stb = 1'b1; bus.io_m0_adr = 32'h300;
        for (int c = 1; c <= TO; c++) begin
            mid(); check_bus($sformatf("wd_wait%0d", c), 2'b01, 1'b1, 1'b1);
            next_cycle();
        end
        bus.io_s_ack = 1'b1; bus.io_s_dat_r = 64'h5555;
        expect_resp(R_M0_ERR, 1'b0, '0);
        mid(); check_bus("wd_err_cycle", 2'b01, 1'b1, 1'b0);
        next_cycle(); bus.io_s_ack = 1'b0;
        mid(); check_bus("wd_resume", 2'b01, 1'b1, 1'b1);
        for (int c = 2; c <= TO; c++) begin
            next_cycle();
        end
        next_cycle();
        expect_resp(R_M0_ERR, 1'b0, '0);
        mid(); check_bus("wd_err2", 2'b01, 1'b1, 1'b0);
        next_cycle(); bus.io_m0_cyc = 1'b0; bus.io_m0_stb = 1'b0;
        mid(); check_bus("wd_release", 2'b01, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("wd_idle", 2'b00, 1'b0, 1'b0);

        // Spurious slave ack while idle and while the owner has no strobe.
        next_cycle(); bus.io_s_ack = 1'b1; bus.io_s_dat_r = 64'hBAD;
        mid(); check_bus("spur_idle", 2'b00, 1'b0, 1'b0);
        next_cycle(); bus.io_m1_cyc = 1'b1;
        mid(); check_bus("spur_idle_req", 2'b00, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("spur_nostb", 2'b10, 1'b1, 1'b0);

        // Async reset while master 1 owns the bus with a strobe up.
        next_cycle(); bus.io_s_ack = 1'b0; bus.io_m1_stb = 1'b1;
        mid(); check_bus("pre_rst", 2'b10, 1'b1, 1'b1);
        #2 reset = 1'b0;
        #1 check_bus("async_rst", 2'b00, 1'b0, 1'b0);
        bus.io_m0_cyc = 1'b1;
        mid(); check_bus("in_rst", 2'b00, 1'b0, 1'b0);
        next_cycle(); reset = 1'b1; bus.io_m1_stb = 1'b0;
        mid(); check_bus("post_rst_req", 2'b00, 1'b0, 1'b0);
        next_cycle();
        mid(); check_bus("post_rst_tie", 2'b01, 1'b1, 1'b0);
        next_cycle(); bus.io_m0_cyc = 1'b0; bus.io_m1_cyc = 1'b0;
        next_cycle();
        next_cycle();
        mid();
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
